// File: rtl/ti_bus_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ti_bus_responder_pkg
// Brief    : Shared types and constants for the TI bus responder.
// Revision : 1.0 - initial release
// ============================================================================
package ti_bus_responder_pkg;

  // Default width of the opaque TI request tag.
  localparam int c_TI_TAG_WIDTH = 8;

  // Serializer states: wait for work, hand a lane to the engine,
  // wait for its result, present the collected response.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } ti_state_e;

  // Lane pointer width; a single-lane build still needs one bit.
  function automatic int lane_ptr_width(input int num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ti_bus_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ti_bus_responder_fifo
// Brief    : Request FIFO. Registered storage, no write-through; simultaneous
//            push and pop are accepted at any occupancy, including full.
// Revision : 1.0 - initial release
// ============================================================================
module ti_bus_responder_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                  (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd_ptr[c_AW-1:0]];

  // Storage: cleared on reset so the head never carries stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end
  end

  // Pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ti_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : ti_bus_responder
// Brief    : TI bus responder. Buffers multi-lane requests, feeds active lanes
//            one at a time to a single-lane engine in ascending order, and
//            returns one response per request carrying the original tag.
// Revision : 1.0 - initial release
// ============================================================================
module ti_bus_responder
  import ti_bus_responder_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int DATAW     = 64,
  parameter int RESW      = 32,
  parameter int TAG_WIDTH = c_TI_TAG_WIDTH,
  parameter int REQ_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [NUM_LANES-1:0]      req_mask,
  input  logic [NUM_LANES*DATAW-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [NUM_LANES-1:0]      rsp_mask,
  output logic [NUM_LANES*RESW-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  output logic                      eng_req_valid,
  input  logic                      eng_req_ready,
  output logic [DATAW-1:0]          eng_req_data,
  input  logic                      eng_rsp_valid,
  input  logic [RESW-1:0]           eng_rsp_data,
  output logic                      busy
);

  localparam int c_LW = lane_ptr_width(NUM_LANES);

  typedef struct packed {
    logic [NUM_LANES-1:0]       mask;
    logic [NUM_LANES*DATAW-1:0] data;
    logic [TAG_WIDTH-1:0]       tag;
  } ti_req_data_t;

  ti_req_data_t              w_push_req;
  ti_req_data_t              w_head;
  logic                      w_empty;
  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;

  ti_state_e                 r_state;
  logic [c_LW-1:0]           r_lane;
  logic [NUM_LANES*RESW-1:0] r_result;

  logic                      w_first_hit;
  logic [c_LW-1:0]           w_first_lane;
  logic                      w_next_hit;
  logic [c_LW-1:0]           w_next_lane;
  logic [DATAW-1:0]          w_lane_data;

  assign w_push_req = '{mask: req_mask, data: req_data, tag: req_tag};

  // Bus side of the FIFO; ready is held low while reset is asserted.
  assign req_ready = !w_full && !reset;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == S_RESP) && rsp_ready;

  ti_bus_responder_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH ($bits(ti_req_data_t))
  ) u_req_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_push_req),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  // Lowest set lane overall, and lowest set lane strictly above the pointer.
  // Scanning downward lets the last hit win, i.e. the lowest index.
  always_comb begin
    w_first_hit  = 1'b0;
    w_first_lane = '0;
    w_next_hit   = 1'b0;
    w_next_lane  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_head.mask[i]) begin
        w_first_hit  = 1'b1;
        w_first_lane = c_LW'(i);
      end
      if (w_head.mask[i] && (c_LW'(i) > r_lane)) begin
        w_next_hit  = 1'b1;
        w_next_lane = c_LW'(i);
      end
    end
  end

  // Payload of the lane currently addressed by the pointer.
  always_comb begin
    w_lane_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (c_LW'(i) == r_lane) begin
        w_lane_data = w_head.data[i*DATAW +: DATAW];
      end
    end
  end

  // Lane serializer: walks the active lanes of the head request and
  // accumulates engine results until the response is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_lane   <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_result <= '0;
            if (w_first_hit) begin
              r_lane  <= w_first_lane;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          if (eng_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_rsp_valid) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              if (c_LW'(i) == r_lane) begin
                r_result[i*RESW +: RESW] <= eng_rsp_data;
              end
            end
            if (w_next_hit) begin
              r_lane  <= w_next_lane;
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state register and forced to zero
  // whenever the corresponding valid is low.
  assign eng_req_valid = (r_state == S_ISSUE);
  assign eng_req_data  = eng_req_valid ? w_lane_data : '0;
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_mask      = rsp_valid ? w_head.mask : '0;
  assign rsp_tag       = rsp_valid ? w_head.tag : '0;
  assign rsp_data      = rsp_valid ? r_result : '0;
  assign busy          = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ti_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ti_bus_responder
// Brief    : Self-checking bench for ti_bus_responder with an engine model
//            and a request-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ti_bus_responder;

  localparam int NL = 4;
  localparam int DW = 64;
  localparam int RW = 32;
  localparam int TW = 8;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [NL-1:0]     req_mask;
  logic [NL*DW-1:0]  req_data;
  logic [TW-1:0]     req_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [NL-1:0]     rsp_mask;
  logic [NL*RW-1:0]  rsp_data;
  logic [TW-1:0]     rsp_tag;
  logic              eng_req_valid;
  logic              eng_req_ready;
  logic [DW-1:0]     eng_req_data;
  logic              eng_rsp_valid;
  logic [RW-1:0]     eng_rsp_data;
  logic              busy;

  typedef struct {
    logic [NL-1:0]    mask;
    logic [NL*DW-1:0] data;
    logic [TW-1:0]    tag;
  } req_s;

  req_s        exp_q[$];
  logic [DW-1:0] eng_log[$];
  int          checks = 0;
  int          errors = 0;
  bit          eng_auto = 1'b1;
  bit          eng_rand = 1'b0;
  int          stray_cnt = 0;
  int          stray_seen = 0;
  int          eng_d;
  logic [DW-1:0] eng_cap;
  logic        quiet;

  ti_bus_responder #(
    .NUM_LANES (NL),
    .DATAW     (DW),
    .RESW      (RW),
    .TAG_WIDTH (TW),
    .REQ_DEPTH (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_mask      (req_mask),
    .req_data      (req_data),
    .req_tag       (req_tag),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_mask      (rsp_mask),
    .rsp_data      (rsp_data),
    .rsp_tag       (rsp_tag),
    .eng_req_valid (eng_req_valid),
    .eng_req_ready (eng_req_ready),
    .eng_req_data  (eng_req_data),
    .eng_rsp_valid (eng_rsp_valid),
    .eng_rsp_data  (eng_rsp_data),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Engine model: result = payload + 100, returned after 1 (or 1..3) cycles.
  // Also injects a single stray result on request from the main sequence.
  initial begin
    eng_rsp_valid = 1'b0;
    eng_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_seen) begin
        stray_seen = stray_cnt;
        @(posedge clk); #1;
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = $urandom;
        @(posedge clk); #1;
        eng_rsp_valid = 1'b0;
        eng_rsp_data  = '0;
      end else if (eng_auto && eng_req_valid && eng_req_ready) begin
        eng_cap = eng_req_data;
        eng_log.push_back(eng_cap);
        eng_d = eng_rand ? int'($urandom_range(1, 3)) : 1;
        repeat (eng_d) @(posedge clk);
        #1;
        eng_rsp_valid = 1'b1;
        eng_rsp_data  = RW'(eng_cap + 64'd100);
        @(posedge clk); #1;
        eng_rsp_valid = 1'b0;
        eng_rsp_data  = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [NL*DW-1:0] rand_data();
    logic [NL*DW-1:0] d;
    for (int i = 0; i < NL * DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference response: active lanes get payload+100, inactive lanes 0.
  function automatic logic [NL*RW-1:0] model_rsp(input req_s r);
    logic [NL*RW-1:0] o;
    for (int i = 0; i < NL; i++) begin
      o[i*RW +: RW] = r.mask[i] ? RW'(r.data[i*DW +: DW] + 64'd100) : RW'(0);
    end
    return o;
  endfunction

  task automatic do_req(input logic [NL-1:0] m, input logic [NL*DW-1:0] d, input logic [TW-1:0] t);
    req_s r;
    int n;
    req_valid = 1'b1;
    req_mask  = m;
    req_data  = d;
    req_tag   = t;
    n = 0;
    while (!req_ready && n < 400) begin
      step();
      n++;
    end
    check("req_accept", 256'(req_ready), 256'(1));
    r.mask = m;
    r.data = d;
    r.tag  = t;
    exp_q.push_back(r);
    step();
    req_valid = 1'b0;
    req_mask  = '0;
    req_data  = '0;
    req_tag   = '0;
  endtask

  task automatic collect(input int hold);
    req_s e;
    logic [NL*RW-1:0] ed;
    int n;
    n = 0;
    while (!rsp_valid && n < 400) begin
      step();
      n++;
    end
    check("rsp_wait", 256'(rsp_valid), 256'(1));
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL rsp_unexpected: observed tag %0h expected no response", rsp_tag);
    end else begin
      e  = exp_q.pop_front();
      ed = model_rsp(e);
      for (int h = 0; h <= hold; h++) begin
        check("rsp_valid", 256'(rsp_valid), 256'(1));
        check("rsp_mask", 256'(rsp_mask), 256'(e.mask));
        check("rsp_tag", 256'(rsp_tag), 256'(e.tag));
        check("rsp_data", 256'(rsp_data), 256'(ed));
        if (h < hold) step();
      end
      check("eng_count", 256'(eng_log.size()), 256'($countones(e.mask)));
      for (int i = 0; i < NL; i++) begin
        if (e.mask[i] && eng_log.size() > 0) begin
          check("eng_lane", 256'(eng_log.pop_front()), 256'(e.data[i*DW +: DW]));
        end
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [NL*DW-1:0] d;
    int n;

    reset         = 1'b1;
    req_valid     = 1'b0;
    req_mask      = '0;
    req_data      = '0;
    req_tag       = '0;
    rsp_ready     = 1'b0;
    eng_req_ready = 1'b1;
    repeat (3) step();

    // Reset state.
    check("rst_outputs", 256'({req_ready, rsp_valid, eng_req_valid, busy,
                                rsp_mask, rsp_tag, rsp_data, eng_req_data}), 256'(0));
    reset = 1'b0;
    step();
    check("post_rst_ready", 256'(req_ready), 256'(1));
    check("post_rst_busy", 256'(busy), 256'(0));

    // Full mask, lane payloads 1..4, with issue latency.
    do_req(4'b1111, {64'd4, 64'd3, 64'd2, 64'd1}, 8'h5A);
    check("lat_idle", 256'(eng_req_valid), 256'(0));
    check("lat_busy", 256'(busy), 256'(1));
    step();
    check("lat_issue", 256'(eng_req_valid), 256'(1));
    check("lat_lane0", 256'(eng_req_data), 256'(1));
    collect(0);

    // Sparse mask.
    do_req(4'b1010, rand_data(), 8'h11);
    collect(0);

    // Zero mask: response two cycles after acceptance, no engine traffic.
    do_req(4'b0000, rand_data(), 8'h22);
    check("zero_lat_idle", 256'(rsp_valid), 256'(0));
    step();
    check("zero_lat_resp", 256'(rsp_valid), 256'(1));
    collect(0);

    // Back-to-back with response backpressure.
    do_req(4'($urandom), rand_data(), 8'h01);
    do_req(4'($urandom), rand_data(), 8'h02);
    check("full_ready", 256'(req_ready), 256'(0));
    fork
      do_req(4'($urandom), rand_data(), 8'h03);
      begin
        repeat (3) collect(0);
      end
    join
    check("b2b_idle", 256'(busy), 256'(0));

    // Engine and response backpressure.
    eng_req_ready = 1'b0;
    d = rand_data();
    do_req(4'b0110, d, 8'h33);
    n = 0;
    while (!eng_req_valid && n < 50) begin
      step();
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_eng_valid", 256'(eng_req_valid), 256'(1));
      check("bp_eng_data", 256'(eng_req_data), 256'(d[DW +: DW]));
      check("bp_eng_none", 256'(eng_log.size()), 256'(0));
      step();
    end
    eng_req_ready = 1'b1;
    collect(4);
    check("bp_no_dup", 256'(rsp_valid), 256'(0));

    // Randomized traffic with variable engine delay and response stalls.
    eng_rand = 1'b1;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          do_req(4'($urandom), rand_data(), TW'(8'h40 + k));
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        for (int k = 0; k < 16; k++) collect(int'($urandom_range(0, 2)));
      end
    join
    eng_rand = 1'b0;
    check("rand_drain", 256'(exp_q.size()), 256'(0));

    // Reset while waiting on the engine with two requests queued.
    eng_auto      = 1'b0;
    eng_req_ready = 1'b0;
    do_req(4'b0001, rand_data(), 8'hA1);
    do_req(4'b1111, rand_data(), 8'hA2);
    n = 0;
    while (!eng_req_valid && n < 50) begin
      step();
      n++;
    end
    eng_req_ready = 1'b1;
    step();
    check("wait_state", 256'(eng_req_valid), 256'(0));
    check("wait_busy", 256'(busy), 256'(1));
    check("wait_full", 256'(req_ready), 256'(0));
    reset = 1'b1;
    #1;
    check("async_rst", 256'({req_ready, rsp_valid, eng_req_valid, busy,
                              rsp_mask, rsp_tag, rsp_data, eng_req_data}), 256'(0));
    exp_q.delete();
    eng_log.delete();
    step();
    step();
    reset = 1'b0;
    stray_cnt++;
    quiet = 1'b0;
    repeat (8) begin
      step();
      quiet = quiet | rsp_valid | eng_req_valid | busy;
    end
    check("stray_ignored", 256'(quiet), 256'(0));
    check("rst_ready", 256'(req_ready), 256'(1));
    eng_auto = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
